// File: rtl/responder_pkg.sv
// Shared types and helpers for the quiz responder control core.
package responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_LOCKED  = 3'd2,
      ST_FOUL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   localparam int unsigned KEY_W    = 4;
   localparam int unsigned WINNER_W = 3;
   localparam logic [WINNER_W-1:0] WINNER_NONE = 3'd0;

   // Lowest key index wins; returns contestant number 1..4, or 0 when no key.
   function automatic logic [WINNER_W-1:0] prio_enc(input logic [KEY_W-1:0] k);
      logic [WINNER_W-1:0] w;
      w = WINNER_NONE;
      for (int i = KEY_W - 1; i >= 0; i--) begin
         if (k[i]) w = WINNER_W'(i + 1);
      end
      return w;
   endfunction

endpackage

// File: rtl/sec_tick_edge.sv
// Rising-edge detector turning the seconds square wave into one-cycle ticks.
module sec_tick_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sec_clk,
   output logic tick
);

   logic sec_clk_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sec_clk_d <= 1'b0;
      else        sec_clk_d <= sec_clk;
   end

   assign tick = sec_clk & ~sec_clk_d;

endmodule

// File: rtl/responder_ctrl.sv
// Quiz responder core: key arbitration, answer-window countdown, foul and timeout flags.
module responder_ctrl
   import responder_pkg::*;
#(
   parameter int unsigned COUNT_INIT = 30,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sec_clk,
   input  logic                start,
   input  logic                clear,
   input  logic [KEY_W-1:0]    key,
   output logic [WINNER_W-1:0] winner,
   output logic [CNT_W-1:0]    remaining,
   output logic                armed,
   output logic                locked,
   output logic                foul,
   output logic                timeout,
   output logic                beep
);

   logic tick;

   state_e              state_q, state_d;
   logic [WINNER_W-1:0] winner_q, winner_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic                armed_q, armed_d;
   logic                locked_q, locked_d;
   logic                foul_q, foul_d;
   logic                timeout_q, timeout_d;
   logic                beep_q, beep_d;

   sec_tick_edge u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .sec_clk (sec_clk),
      .tick    (tick)
   );

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      remaining_d = remaining_q;
      beep_d      = 1'b0;

      if (clear) begin
         state_d     = ST_IDLE;
         winner_d    = WINNER_NONE;
         remaining_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (key != '0) begin
                  state_d  = ST_FOUL;
                  winner_d = prio_enc(key);
                  beep_d   = 1'b1;
               end else if (start) begin
                  state_d     = ST_ARMED;
                  remaining_d = CNT_W'(COUNT_INIT);
               end
            end
            ST_ARMED: begin
               // A key arriving with a tick freezes the count before the decrement.
               if (key != '0) begin
                  state_d  = ST_LOCKED;
                  winner_d = prio_enc(key);
                  beep_d   = 1'b1;
               end else if (tick && remaining_q != '0) begin
                  remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_d = ST_TIMEOUT;
                     beep_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      armed_d   = (state_d == ST_ARMED);
      locked_d  = (state_d == ST_LOCKED);
      foul_d    = (state_d == ST_FOUL);
      timeout_d = (state_d == ST_TIMEOUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         winner_q    <= WINNER_NONE;
         remaining_q <= '0;
         armed_q     <= 1'b0;
         locked_q    <= 1'b0;
         foul_q      <= 1'b0;
         timeout_q   <= 1'b0;
         beep_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         remaining_q <= remaining_d;
         armed_q     <= armed_d;
         locked_q    <= locked_d;
         foul_q      <= foul_d;
         timeout_q   <= timeout_d;
         beep_q      <= beep_d;
      end
   end

   assign winner    = winner_q;
   assign remaining = remaining_q;
   assign armed     = armed_q;
   assign locked    = locked_q;
   assign foul      = foul_q;
   assign timeout   = timeout_q;
   assign beep      = beep_q;

endmodule
